// File: rtl/sig_ethernet_rx_packer_pkg.sv
// Shared ethernet definitions: packer state encoding, counter widths and a
// saturating length increment.
package sig_ethernet_rx_packer_pkg;

  localparam int LANE_W = 2;
  localparam int LEN_W  = 16;

  localparam logic [LANE_W-1:0] LANE_LAST = '1;
  localparam logic [LEN_W-1:0]  LEN_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  // Frame lengths stick at all-ones instead of wrapping on jumbo garbage.
  function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] len);
    return (len == LEN_MAX) ? len : len + LEN_W'(1);
  endfunction

endpackage

// File: rtl/sig_ethernet_rx_packer_word_reg.sv
// One-entry output register in front of the 32-bit FIFO write port.
// A load and a write may happen on the same edge; the load wins.
module sig_ethernet_word_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        fifo_wr_vld,
  output logic        full,
  output logic        fifo_wr_en,
  output logic [31:0] fifo_wr_data
);

  assign fifo_wr_en = full & fifo_wr_vld;

  // Hold one word until the FIFO takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full         <= 1'b0;
      fifo_wr_data <= '0;
    end else if (load) begin
      full         <= 1'b1;
      fifo_wr_data <= load_data;
    end else if (fifo_wr_en) begin
      full         <= 1'b0;
    end
  end

endmodule

// File: rtl/sig_ethernet_rx_packer.sv
// Ethernet RX byte stream to 32-bit MSB-first word packer with frame status.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | between frames; first valid byte starts a frame
// ST_PACK  | collecting bytes into words
// ST_FLUSH | last byte seen, waiting for the final word to reach the FIFO
// ST_DROP  | frame is bad (overflow or too long); discard until in_last
module sig_ethernet_rx_packer
  import sig_ethernet_rx_packer_pkg::*;
#(
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_vld,
  input  logic             in_last,
  output logic             fifo_wr_en,
  output logic [31:0]      fifo_wr_data,
  input  logic             fifo_wr_vld,
  output logic             frame_done,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_err
);

  state_t            state;
  logic [LANE_W-1:0] cnt;
  logic [23:0]       acc;
  logic [LEN_W-1:0]  len_cnt;
  logic [LEN_W-1:0]  len_next;
  logic              err_cur;
  logic              err_nxt;
  logic              byte_ok;
  logic              word_done;
  logic              overflow;
  logic              too_long;
  logic              load;
  logic [31:0]       word_cur;
  logic              wr_full;

  // Merge the incoming byte into its lane and classify this cycle's byte.
  always_comb begin
    byte_ok  = in_vld && (state == ST_IDLE || state == ST_PACK);
    word_cur = {in_data, 24'd0};
    case (cnt)
      2'd1:    word_cur = {acc[23:16], in_data, 16'd0};
      2'd2:    word_cur = {acc[23:8], in_data, 8'd0};
      2'd3:    word_cur = {acc, in_data};
      default: word_cur = {in_data, 24'd0};
    endcase
    word_done = byte_ok && (cnt == LANE_LAST || in_last);
    // A held word that leaves on this edge frees the slot for the new one.
    overflow  = word_done && wr_full && !fifo_wr_en;
    len_next  = len_inc(len_cnt);
    too_long  = 32'(len_next) > MAX_LEN;
    load      = word_done && !overflow && !too_long;
  end

  sig_ethernet_word_reg u_word_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .load_data    (word_cur),
    .fifo_wr_vld  (fifo_wr_vld),
    .full         (wr_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data)
  );

  // Frame sequencing, lane/length counting and registered frame status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      acc        <= '0;
      len_cnt    <= '0;
      err_cur    <= 1'b0;
      err_nxt    <= 1'b0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE, ST_PACK: begin
          if (in_vld) begin
            len_cnt <= len_next;
            if (word_done) begin
              cnt <= '0;
              acc <= '0;
            end else begin
              cnt <= cnt + LANE_W'(1);
              acc <= word_cur[31:8];
            end
            if (overflow || too_long) begin
              if (in_last) begin
                // Bad frame ends on this byte: report straight away.
                state      <= ST_IDLE;
                frame_done <= 1'b1;
                frame_len  <= len_next;
                frame_err  <= 1'b1;
                len_cnt    <= '0;
                err_cur    <= 1'b0;
              end else begin
                state   <= ST_DROP;
                err_cur <= 1'b1;
              end
            end else if (in_last) begin
              state <= ST_FLUSH;
            end else begin
              state <= ST_PACK;
            end
          end
        end
        ST_FLUSH: begin
          // Bytes here belong to no frame but taint the next one.
          if (in_vld) err_nxt <= 1'b1;
          if (fifo_wr_en) begin
            state      <= ST_IDLE;
            frame_done <= 1'b1;
            frame_len  <= len_cnt;
            frame_err  <= err_cur;
            len_cnt    <= '0;
            err_cur    <= err_nxt | in_vld;
            err_nxt    <= 1'b0;
          end
        end
        ST_DROP: begin
          if (in_vld) begin
            len_cnt <= len_next;
            if (in_last) begin
              state      <= ST_IDLE;
              frame_done <= 1'b1;
              frame_len  <= len_next;
              frame_err  <= 1'b1;
              len_cnt    <= '0;
              err_cur    <= 1'b0;
              cnt        <= '0;
              acc        <= '0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sig_ethernet_rx_packer.md
SIG_ETHERNET_RX_PACKER -- requirements
Module: sig_ethernet_rx_packer

Interface
REQ-001 Parameter MAX_LEN, default 1518, maximum accepted frame length in bytes.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_data  input  8  received byte.
REQ-005 in_vld  input  1  in_data valid this cycle; no backpressure to the source.
REQ-006 in_last  input  1  qualifies in_vld; marks the last byte of a frame.
REQ-007 fifo_wr_en  output  1  write strobe to the 32-bit write side of the ethernet FIFO.
REQ-008 fifo_wr_data  output  32  packed word.
REQ-009 fifo_wr_vld  input  1  FIFO can accept a word this cycle (not full).
REQ-010 frame_done  output  1  one-cycle pulse at frame completion.
REQ-011 frame_len  output  16  byte count of the completed frame, valid while frame_done is high.
REQ-012 frame_err  output  1  frame overflowed or exceeded MAX_LEN, valid while frame_done is high.

Function
REQ-013 The block SHALL pack bytes MSB-first: the 1st byte of each word goes to [31:24], the 2nd to [23:16], the 3rd to [15:8] and the 4th to [7:0].
REQ-014 A word SHALL complete on the 4th byte, or on any byte with in_last; unused low lanes of a partial word SHALL be zero.
REQ-015 A completed word SHALL load a one-entry output register on the next edge; fifo_wr_en SHALL equal (register full AND fifo_wr_vld).
REQ-016 The register SHALL clear on the edge where fifo_wr_en is high; a word SHALL never be written twice or lost while it is held.
REQ-017 If a word completes while the register still holds an unwritten word, the block SHALL set the error flag, discard the new word and enter DROP.
REQ-018 The state machine SHALL have four states: IDLE, PACK, FLUSH and DROP.
REQ-019 IDLE→PACK on in_vld without in_last; IDLE→FLUSH on a single-byte frame (in_vld with in_last).
REQ-020 PACK→FLUSH on in_vld with in_last; PACK→DROP on overflow or when the byte count exceeds MAX_LEN.
REQ-021 FLUSH→IDLE on the edge where the final word is written; frame_done SHALL pulse in the following cycle.
REQ-022 DROP SHALL ignore bytes until in_vld with in_last, then go to IDLE and pulse frame_done with frame_err=1 in the next cycle; any held word SHALL still be written.
REQ-023 in_last without in_vld SHALL be ignored; in_vld in FLUSH (back-to-back frame) SHALL start a new frame only after the previous frame_done.
REQ-024 Bytes arriving in FLUSH SHALL set the error flag of the new frame.
REQ-025 frame_len SHALL count every accepted byte including dropped ones, saturating at 16'hFFFF.
REQ-026 Words already written before an error SHALL remain in the FIFO; downstream discards them using frame_err.
REQ-027 Latency from the last byte to fifo_wr_en SHALL be 1 cycle when fifo_wr_vld is high.

Reset
REQ-028 On rst_n low, the state SHALL be IDLE; fifo_wr_en, frame_done and frame_err SHALL be 0; fifo_wr_data and frame_len SHALL be 0; the lane counter and the register full flag SHALL be cleared.
REQ-029 Reset mid-frame SHALL discard the partial word and the held word without a write; after release the next in_vld SHALL start a fresh frame.

Structure
REQ-030 The state encoding, the lane-count width (2 bits) and the length-counter width (16) SHALL live in the shared ethernet package.
REQ-031 One sub-module, sig_ethernet_word_reg (the one-entry output register with its write handshake), SHALL be used; all other logic SHALL be flat.

Verification
REQ-032 Bytes 01..08 on consecutive cycles with last on 08, fifo_wr_vld=1 -> words 01020304 and 05060708 are written, frame_len=8, frame_err=0.
REQ-033 Bytes AA,BB,CC with last, ready -> one word AABBCC00 is written, frame_done appears 1 cycle after the write, frame_len=3.
REQ-034 fifo_wr_vld=0 for 3 cycles after the first word completes -> the word is held and written once when ready returns, with no loss.
REQ-035 fifo_wr_vld=0 for the whole 8-byte frame -> the first word is held, the second is dropped, frame_err=1 and frame_len=8.
REQ-036 MAX_LEN=64 with a 70-byte frame -> DROP after byte 65, frame_err=1, frame_len=70, and the next frame is clean.
REQ-037 rst_n asserted after byte 2 -> no write occurs, and the following frame 11,22,33,44 with last produces the word 11223344.
